// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory port between instruction fetch and load/store; grant registered one edge after request, done one edge after mem_ready.
// Requesters hold their level request until done; the port stalls in a grant state until mem_ready or timeout expiry.
module mem_port_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int TIMEOUT       = 16,
    parameter int MAX_LS_STREAK = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_done,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              IFU_addr_en,
    output logic              ALU_addr_en,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              bus_err,
    output logic              busy
);

    localparam int CW = $clog2(TIMEOUT);
    localparam int SW = $clog2(MAX_LS_STREAK + 1);
    localparam logic [CW-1:0] LP_CNT_MAX    = CW'(TIMEOUT - 1);
    localparam logic [SW-1:0] LP_STREAK_MAX = SW'(MAX_LS_STREAK);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        GRANT_IF = 2'd1,
        GRANT_LS = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CW-1:0]     r_cnt;
    logic [SW-1:0]     r_streak;
    logic              w_grant_if;
    logic              w_grant_ls;
    logic              w_ok;
    logic              w_expire;
    logic              w_end;

    logic              r_if_done;
    logic              r_ls_done;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_ls_rdata;
    logic              r_ifu_en;
    logic              r_alu_en;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_bus_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Load/store wins ties until it has taken MAX_LS_STREAK grants in a row over a waiting fetch.
    always_comb begin
        w_next     = r_state;
        w_grant_if = 1'b0;
        w_grant_ls = 1'b0;
        w_ok       = 1'b0;
        w_expire   = 1'b0;
        case (r_state)
            IDLE: begin
                if (ls_req && (!if_req || (r_streak < LP_STREAK_MAX))) begin
                    w_grant_ls = 1'b1;
                    w_next     = GRANT_LS;
                end else if (if_req) begin
                    w_grant_if = 1'b1;
                    w_next     = GRANT_IF;
                end
            end
            GRANT_IF, GRANT_LS: begin
                if (mem_ready) begin
                    w_ok   = 1'b1;
                    w_next = IDLE;
                end else if (r_cnt == LP_CNT_MAX) begin
                    w_expire = 1'b1;
                    w_next   = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_end = w_ok || w_expire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_streak    <= '0;
            r_if_done   <= 1'b0;
            r_ls_done   <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
            r_ifu_en    <= 1'b0;
            r_alu_en    <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_bus_err   <= 1'b0;
        end else begin
            r_if_done <= w_end && (r_state == GRANT_IF);
            r_ls_done <= w_end && (r_state == GRANT_LS);
            r_bus_err <= w_expire;
            if (w_grant_ls) begin
                r_mem_addr  <= ls_addr;
                r_mem_wdata <= ls_wdata;
                r_mem_we    <= ls_we;
                r_mem_req   <= 1'b1;
                r_alu_en    <= 1'b1;
                r_ifu_en    <= 1'b0;
                r_cnt       <= '0;
                if (!if_req) begin
                    r_streak <= '0;
                end else if (r_streak != LP_STREAK_MAX) begin
                    r_streak <= r_streak + 1'b1;
                end
            end else if (w_grant_if) begin
                r_mem_addr  <= if_addr;
                r_mem_wdata <= '0;
                r_mem_we    <= 1'b0;
                r_mem_req   <= 1'b1;
                r_ifu_en    <= 1'b1;
                r_alu_en    <= 1'b0;
                r_cnt       <= '0;
                r_streak    <= '0;
            end else if (w_end) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
                r_ifu_en  <= 1'b0;
                r_alu_en  <= 1'b0;
                if (r_state == GRANT_IF) begin
                    r_if_rdata <= w_ok ? mem_rdata : '0;
                end else begin
                    r_ls_rdata <= w_ok ? mem_rdata : '0;
                end
            end else if (r_state != IDLE) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign if_done     = r_if_done;
    assign ls_done     = r_ls_done;
    assign if_rdata    = r_if_rdata;
    assign ls_rdata    = r_ls_rdata;
    assign IFU_addr_en = r_ifu_en;
    assign ALU_addr_en = r_alu_en;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign bus_err     = r_bus_err;
    assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected completions, a negedge monitor pops and compares them.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        IFU_addr_en;
    logic        ALU_addr_en;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        bus_err;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        bit          is_ls;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t exp_q[$];

    mem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT(16), .MAX_LS_STREAK(3)
    ) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_done(ls_done), .ls_rdata(ls_rdata),
        .IFU_addr_en(IFU_addr_en), .ALU_addr_en(ALU_addr_en),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .bus_err(bus_err), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!reset) begin
            check("enables_onehot", {63'd0, IFU_addr_en & ALU_addr_en}, 64'd0);
            check("bus_err_with_done", {63'd0, bus_err & ~(if_done | ls_done)}, 64'd0);
            if (if_done || ls_done) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_done: got if_done=%0b ls_done=%0b expected none", if_done, ls_done);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("done_winner", {62'd0, ls_done, if_done}, e.is_ls ? 64'd2 : 64'd1);
                    check("done_rdata", {32'd0, (e.is_ls ? ls_rdata : if_rdata)}, {32'd0, e.rdata});
                    check("done_bus_err", {63'd0, bus_err}, {63'd0, e.err});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit is_ls, input logic [31:0] rd, input bit err);
        exp_t e;
        e.is_ls = is_ls;
        e.rdata = rd;
        e.err   = err;
        exp_q.push_back(e);
    endtask

    initial begin
        bit order [8];
        reset = 1'b1; if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0;
        ls_wdata = 0; mem_rdata = 0; mem_ready = 0;
        for (int k = 0; k < 8; k++) order[k] = (k % 4) != 3;

        @(negedge clk);
        check("reset_outputs",
              {32'd0, 24'd0, mem_req, mem_we, IFU_addr_en, ALU_addr_en, if_done, ls_done, bus_err, busy}, 64'd0);
        check("reset_rdata", {if_rdata, ls_rdata}, 64'd0);
        check("reset_mem_addr", {32'd0, mem_addr}, 64'd0);
        step();
        reset = 1'b0;

        // Reset during GRANT_LS drops the access with no done.
        ls_req = 1; ls_addr = 32'h40;
        step();
        check("ls_grant_before_reset", {62'd0, mem_req, ALU_addr_en}, 64'd3);
        #2 reset = 1'b1;
        #1;
        check("async_reset_outputs",
              {24'd0, mem_addr, mem_req, mem_we, IFU_addr_en, ALU_addr_en, if_done, ls_done, bus_err, busy}, 64'd0);
        ls_req = 0;
        step();
        step();
        reset = 1'b0;
        step();

        // Single fetch; mem_ready is already high in IDLE and must be ignored.
        if_req = 1; if_addr = 32'h100; mem_rdata = 32'h00500093; mem_ready = 1;
        push(0, 32'h00500093, 0);
        step();
        check("fetch_grant", {61'd0, mem_req, IFU_addr_en, mem_we}, 64'd6);
        check("fetch_addr", {32'd0, mem_addr}, 64'h100);
        check("fetch_no_done_yet", {63'd0, if_done}, 64'd0);
        step();
        if_req = 0; mem_ready = 0;
        @(negedge clk);
        check("fetch_done_latency", {62'd0, if_done, busy}, 64'd2);
        step();

        // Store: three wait cycles, ready on the fourth grant cycle.
        ls_req = 1; ls_we = 1; ls_addr = 32'h2000; ls_wdata = 32'hDEADBEEF; mem_rdata = 32'h12345678;
        push(1, 32'h12345678, 0);
        step();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1;
            @(negedge clk);
            check("store_ctrl", {61'd0, mem_we, ALU_addr_en, IFU_addr_en}, 64'd6);
            check("store_addr_data", {mem_addr, mem_wdata}, {32'h2000, 32'hDEADBEEF});
            check("store_no_done_early", {63'd0, ls_done}, 64'd0);
            step();
        end
        mem_ready = 0; ls_req = 0; ls_we = 0;
        @(negedge clk);
        check("store_done", {62'd0, ls_done, bus_err}, 64'd2);
        step();

        // Starvation guard: LS,LS,LS,IF repeating with both requests held.
        if_req = 1; ls_req = 1; if_addr = 32'h300; ls_addr = 32'h400; mem_ready = 1;
        for (int k = 0; k < 8; k++) begin
            mem_rdata = 32'hA5A50000 + k;
            push(order[k], 32'hA5A50000 + k, 0);
            step();
            check("streak_grant", {62'd0, ALU_addr_en, IFU_addr_en}, order[k] ? 64'd2 : 64'd1);
            check("streak_addr", {32'd0, mem_addr}, order[k] ? 64'h400 : 64'h300);
            step();
        end
        if_req = 0; ls_req = 0; mem_ready = 0;
        step();

        // Timeout: 16 grant cycles without ready.
        if_req = 1; if_addr = 32'h500; mem_rdata = 32'hFFFFFFFF;
        push(0, 32'h0, 1);
        step();
        repeat (15) step();
        @(negedge clk);
        check("timeout_cycle16_still_waiting", {61'd0, mem_req, if_done, bus_err}, 64'd4);
        step();
        if_req = 0;
        @(negedge clk);
        check("timeout_expired", {60'd0, if_done, bus_err, busy, mem_req}, 64'd12);
        step();
        step();
        check("bus_err_pulse", {63'd0, bus_err}, 64'd0);

        // Ready exactly on cycle 16 wins over expiry.
        if_req = 1; if_addr = 32'h600; mem_rdata = 32'hCAFEF00D;
        push(0, 32'hCAFEF00D, 0);
        step();
        repeat (15) step();
        mem_ready = 1;
        step();
        mem_ready = 0; if_req = 0;
        @(negedge clk);
        check("ready_at_expiry", {62'd0, if_done, bus_err}, 64'd2);
        step();

        // Request dropped and address changed mid-grant.
        ls_req = 1; ls_we = 0; ls_addr = 32'h700; mem_rdata = 32'h0BADC0DE;
        push(1, 32'h0BADC0DE, 0);
        step();
        ls_req = 0; ls_addr = 32'h999; ls_wdata = 32'h55;
        @(negedge clk);
        check("drop_addr_held_1", {32'd0, mem_addr}, 64'h700);
        step();
        mem_ready = 1;
        @(negedge clk);
        check("drop_addr_held_2", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, 32'h700});
        step();
        mem_ready = 0;
        @(negedge clk);
        check("drop_done", {63'd0, ls_done}, 64'd1);
        step();
        step();
        step();

        check("rdata_hold", {if_rdata, ls_rdata}, {32'hCAFEF00D, 32'h0BADC0DE});
        check("all_done_seen", 64'(exp_q.size()), 64'd0);
        check("idle_at_end", {62'd0, busy, mem_req}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
